// File: rtl/uart_rx_timing_gen_if.sv
// ----------------------------------------------------------------------------
// uart_rx_timing_gen_if
// Bundles the control inputs and timing strobes exchanged between the UART RX
// FSM (master) and the oversampling timing generator (slave).
//
// Signals (direction seen from the slave):
//   enable, prescale, data_len, par_en, stop2_en      in  frame control/config
//   edge_cnt, bit_cnt                                 out position within frame
//   sample_en, sample_idx, bit_done, frame_done       out timing strobes
//   busy, cfg_err                                     out status
//   frame_cnt_clr (in), frame_cnt (out)               only with
//                                                     UART_RX_TIMING_FRAME_CNT_EN
// ----------------------------------------------------------------------------
interface uart_rx_timing_gen_if #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
);
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            data_len;
    logic                  par_en;
    logic                  stop2_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sample_en;
    logic [1:0]            sample_idx;
    logic                  bit_done;
    logic                  frame_done;
    logic                  busy;
    logic                  cfg_err;
`ifdef UART_RX_TIMING_FRAME_CNT_EN
    logic                  frame_cnt_clr;
    logic [15:0]           frame_cnt;
`endif

    modport master (
        output enable, prescale, data_len, par_en, stop2_en,
`ifdef UART_RX_TIMING_FRAME_CNT_EN
        output frame_cnt_clr,
        input  frame_cnt,
`endif
        input  edge_cnt, bit_cnt, sample_en, sample_idx,
        input  bit_done, frame_done, busy, cfg_err
    );

    modport slave (
        input  enable, prescale, data_len, par_en, stop2_en,
`ifdef UART_RX_TIMING_FRAME_CNT_EN
        input  frame_cnt_clr,
        output frame_cnt,
`endif
        output edge_cnt, bit_cnt, sample_en, sample_idx,
        output bit_done, frame_done, busy, cfg_err
    );
endinterface

// File: rtl/uart_rx_timing_gen.sv
// ----------------------------------------------------------------------------
// uart_rx_timing_gen
// Oversampling timing generator for the UART receiver. Counts oversampling
// edges within each bit and bits within each frame, and emits mid-bit sample
// strobes plus bit-done / frame-done pulses. Prescale and frame length are
// latched at frame start so config changes mid-frame do not disturb timing.
//
// Ports:
//   clk    in  RX-domain clock
//   reset  in  asynchronous active-low reset
//   tif    slave modport of uart_rx_timing_gen_if (control in, strobes out)
//
// Optional feature: define UART_RX_TIMING_FRAME_CNT_EN to add a saturating
// 16-bit completed-frame counter (tif.frame_cnt) with synchronous clear
// (tif.frame_cnt_clr, wins over a simultaneous increment).
// ----------------------------------------------------------------------------
module uart_rx_timing_gen #(
    parameter int unsigned PRESCALE_W    = 6,
    parameter int unsigned BIT_CNT_W     = 4,
    parameter int unsigned MAX_DATA_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_timing_gen_if.slave tif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_HOLD
    } state_t;

    localparam logic [3:0]            LP_MAX_DL = 4'(MAX_DATA_BITS);
    localparam logic [PRESCALE_W-1:0] LP_MIN_P  = PRESCALE_W'(4);

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [PRESCALE_W-1:0] r_p_lat;
    logic [PRESCALE_W-1:0] r_mid;
    logic [BIT_CNT_W-1:0]  r_fl;
    logic                  r_sample_en;
    logic [1:0]            r_sample_idx;
    logic                  r_bit_done;
    logic                  r_frame_done;

    state_t                w_state_nxt;
    logic [PRESCALE_W-1:0] w_edge_nxt;
    logic [BIT_CNT_W-1:0]  w_bit_nxt;
    logic [PRESCALE_W-1:0] w_p_nxt;
    logic [PRESCALE_W-1:0] w_mid_nxt;
    logic [BIT_CNT_W-1:0]  w_fl_nxt;
    logic [BIT_CNT_W-1:0]  w_fl_cfg;
    logic                  w_cfg_err;
    logic                  w_sample_en_nxt;
    logic [1:0]            w_sample_idx_nxt;
    logic                  w_bit_done_nxt;
    logic                  w_frame_done_nxt;

    assign w_cfg_err = (tif.prescale < LP_MIN_P) ||
                       (tif.data_len < 4'd5) || (tif.data_len > LP_MAX_DL);

    // start + data + parity + stop(s)
    assign w_fl_cfg = BIT_CNT_W'(2) + BIT_CNT_W'(tif.data_len) +
                      BIT_CNT_W'(tif.par_en) + BIT_CNT_W'(tif.stop2_en);

    // Next-state and next-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = '0;
        w_bit_nxt   = '0;
        w_p_nxt     = r_p_lat;
        w_mid_nxt   = r_mid;
        w_fl_nxt    = r_fl;
        case (r_state)
            S_IDLE: begin
                if (tif.enable && !w_cfg_err) begin
                    w_state_nxt = S_COUNT;
                    w_p_nxt     = tif.prescale;
                    w_mid_nxt   = tif.prescale >> 1;
                    w_fl_nxt    = w_fl_cfg;
                end
            end
            S_COUNT: begin
                if (!tif.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_edge_cnt == r_p_lat - PRESCALE_W'(1)) begin
                    if (r_bit_cnt == r_fl - BIT_CNT_W'(1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_bit_nxt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end else begin
                    w_edge_nxt = r_edge_cnt + PRESCALE_W'(1);
                    w_bit_nxt  = r_bit_cnt;
                end
            end
            S_HOLD: begin
                if (!tif.enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the *next* counter values so that, once
    // registered, they line up with the edge_cnt/bit_cnt they describe.
    // Gating on the next state suppresses them on abort and outside COUNT.
    always_comb begin
        w_sample_en_nxt  = 1'b0;
        w_sample_idx_nxt = '0;
        w_bit_done_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        if (w_state_nxt == S_COUNT) begin
            if ((w_edge_nxt >= w_mid_nxt - PRESCALE_W'(1)) &&
                (w_edge_nxt <= w_mid_nxt + PRESCALE_W'(1))) begin
                w_sample_en_nxt  = 1'b1;
                w_sample_idx_nxt = 2'(w_edge_nxt - (w_mid_nxt - PRESCALE_W'(1)));
            end
            if (w_edge_nxt == w_p_nxt - PRESCALE_W'(1)) begin
                w_bit_done_nxt   = 1'b1;
                w_frame_done_nxt = (w_bit_nxt == w_fl_nxt - BIT_CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_p_lat      <= '0;
            r_mid        <= '0;
            r_fl         <= '0;
            r_sample_en  <= 1'b0;
            r_sample_idx <= '0;
            r_bit_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_edge_cnt   <= w_edge_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_p_lat      <= w_p_nxt;
            r_mid        <= w_mid_nxt;
            r_fl         <= w_fl_nxt;
            r_sample_en  <= w_sample_en_nxt;
            r_sample_idx <= w_sample_idx_nxt;
            r_bit_done   <= w_bit_done_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign tif.edge_cnt   = r_edge_cnt;
    assign tif.bit_cnt    = r_bit_cnt;
    assign tif.sample_en  = r_sample_en;
    assign tif.sample_idx = r_sample_idx;
    assign tif.bit_done   = r_bit_done;
    assign tif.frame_done = r_frame_done;
    assign tif.busy       = (r_state == S_COUNT);
    assign tif.cfg_err    = w_cfg_err;

`ifdef UART_RX_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (tif.frame_cnt_clr) begin
            r_frame_cnt <= '0;
        end else if (r_frame_done && (r_frame_cnt != '1)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign tif.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: doc/uart_rx_timing_gen.md
Name: uart_rx_timing_gen

Overview:
Parametrised oversampling timing generator for the UART receiver. It replaces the plain edge/bit counter.
- Counts oversampling edges within each bit and bits within each frame.
- Frame length is configurable: data length, parity, one or two stop bits.
- Emits mid-bit sample strobes plus bit-done and frame-done pulses, consumed by the RX FSM, data sampler, deserializer and parity/stop checkers.
- Prescale is latched per frame, so mid-frame config changes cannot corrupt timing.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt (maximum prescale 2^PRESCALE_W-1)
BIT_CNT_W, 4, width of bit_cnt; must hold max frame length 1+MAX_DATA_BITS+1+2
MAX_DATA_BITS, 8, largest legal data_len

Ports:
clk  input  1  system clock (RX domain)
reset  input  1  asynchronous active-low reset
enable  input  1  from RX FSM; high = frame in progress, low = abort/idle
prescale  input  PRESCALE_W  oversampling ratio
data_len  input  4  data bits per frame, legal range 5..MAX_DATA_BITS
par_en  input  1  parity bit present
stop2_en  input  1  two stop bits
edge_cnt  output  PRESCALE_W  edge index within the current bit
bit_cnt  output  BIT_CNT_W  bit index within the frame (0 = start)
sample_en  output  1  high on the three mid-bit edges
sample_idx  output  2  0/1/2 = which mid-bit sample
bit_done  output  1  one-cycle pulse on the last edge of each bit
frame_done  output  1  one-cycle pulse on the last edge of the last bit
busy  output  1  state == COUNT
cfg_err  output  1  combinational; current prescale/data_len is illegal

Behaviour:
- Reset (reset=0, async): state=IDLE; edge_cnt=0, bit_cnt=0, sample_en=0, sample_idx=0, bit_done=0, frame_done=0, busy=0; latched registers cleared.
- Legality rules:
  - Prescale is legal when prescale >= 4.
  - data_len is legal when 5 <= data_len <= MAX_DATA_BITS.
  - cfg_err = !(both legal); it is purely combinational on the live inputs.
- Frame length: FL = 1 + data_len + par_en + 1 + stop2_en, computed and latched at frame start.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - Counters are held at 0.
  - If enable=1 and cfg_err=0: latch prescale, FL and mid = prescale>>1, then go to COUNT. edge_cnt=0 and bit_cnt=0 are visible on the next cycle.
  - If enable=1 and cfg_err=1: stay in IDLE.
- COUNT, each cycle:
  - If edge_cnt == P_lat-1: edge_cnt<=0 and bit_done=1 (registered, aligned with that edge value).
    - If in addition bit_cnt == FL-1: frame_done=1 together with bit_done, bit_cnt<=0, next state HOLD.
    - Otherwise bit_cnt<=bit_cnt+1.
  - Otherwise edge_cnt<=edge_cnt+1.
- Strobe outputs are registered and asserted in the same cycle the corresponding edge_cnt value is visible:
  - bit_done and frame_done.
  - sample_en when edge_cnt is in {mid-1, mid, mid+1}.
  - sample_idx = edge_cnt-(mid-1) during sample_en, 0 otherwise.
- HOLD:
  - Counters are held at 0 and there are no strobes.
  - Return to IDLE when enable=0. A new frame therefore always needs enable to drop first.
- enable=0 in COUNT (abort): next cycle state=IDLE, counters=0. Any strobe that would have fired that cycle is suppressed.
- Input changes while busy (prescale, data_len, par_en, stop2_en): ignored until the next frame.
- Odd prescale: mid = floor(P/2). At P=4, samples fall on edges 1,2,3.
- Wrap-around: edge_cnt never exceeds P_lat-1, and bit_cnt never exceeds FL-1.

Optional Feature:
- Macro: UART_RX_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt[15:0].
  - Increments on each frame_done and saturates at 16'hFFFF.
  - Adds input frame_cnt_clr; a synchronous clear that wins over a simultaneous increment.
  - Reset value 0.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- P=8, data_len=8, par_en=0, stop2_en=0, enable held high -> FL=10.
  - 80 COUNT cycles; bit_done exactly 10 times; frame_done once, at bit_cnt=9, edge_cnt=7.
  - sample_en at edges 3,4,5 with idx 0,1,2; HOLD until enable drops.
- P=16, data_len=7, par_en=1, stop2_en=1 -> FL=11.
  - 176 cycles; samples at edges 7,8,9.
  - Changing prescale to 8 mid-frame has no effect.
- Abort: enable dropped at bit_cnt=3, edge_cnt=2 -> next cycle IDLE, counters 0, no bit_done or frame_done.
- prescale=3 or data_len=4 with enable=1 -> cfg_err=1, busy stays 0, counters 0.
  - After prescale=8 is applied, the frame starts.
- Async reset pulse mid-frame, asserted between clock edges -> all outputs 0 immediately.
  - After release with enable still high, a fresh frame starts from bit 0.
- With UART_RX_TIMING_FRAME_CNT_EN defined:
  - 3 frames -> frame_cnt=3.
  - frame_cnt_clr asserted in the same cycle as frame_done -> frame_cnt=0.
  - Preloaded at 16'hFFFF plus one more frame -> frame_cnt stays 16'hFFFF.
